// File: rtl/mean2_pair_seq_f32.sv
// Pairs consecutive f32 samples for an external 2-input mean stage, waits for a
// fresh rising edge of its ready flag (or times out) and holds the result for downstream.
module mean2_pair_seq_f32 #(
    parameter int unsigned TIMEOUT = 32'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] pair_a,
    output logic [31:0] pair_b,
    input  logic        mean_rdy,
    input  logic [31:0] mean_in,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HAVE_A = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Timeout fires on the WAIT cycle whose count is TIMEOUT-1, i.e. after TIMEOUT WAIT cycles.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 32'd1);
    localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;

    state_t      state_r;
    state_t      state_s;
    logic        in_ready_r;
    logic [31:0] pair_a_r;
    logic [31:0] pair_b_r;
    logic [31:0] out_data_r;
    logic        out_valid_r;
    logic        timeout_err_r;
    logic [7:0]  cnt_r;
    logic        rdy_prev_r;

    logic        in_xfer_s;
    logic        out_xfer_s;
    logic        rdy_edge_s;
    logic        cnt_last_s;
    logic        load_a_s;
    logic        load_b_s;
    logic        copy_b_s;
    logic        cap_mean_s;
    logic        cap_nan_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;
    assign rdy_edge_s = mean_rdy & ~rdy_prev_r;
    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Next-state decode and the load strobes that go with each transition.
    always_comb begin
        state_s    = state_r;
        load_a_s   = 1'b0;
        load_b_s   = 1'b0;
        copy_b_s   = 1'b0;
        cap_mean_s = 1'b0;
        cap_nan_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_xfer_s) begin
                    load_a_s = 1'b1;
                    state_s  = ST_HAVE_A;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_HAVE_A: begin
                // A real sample beats a simultaneous flush.
                if (in_xfer_s) begin
                    load_b_s = 1'b1;
                    state_s  = ST_ISSUE;
                end else if (flush) begin
                    copy_b_s = 1'b1;
                    state_s  = ST_ISSUE;
                end else begin
                    state_s  = ST_HAVE_A;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // An edge on the final count still wins over the timeout.
                if (rdy_edge_s) begin
                    cap_mean_s = 1'b1;
                    state_s    = ST_HOLD;
                end else if (cnt_last_s) begin
                    cap_nan_s  = 1'b1;
                    state_s    = ST_HOLD;
                end else begin
                    state_s    = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_xfer_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it never sees in_valid/out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ST_IDLE) || (state_s == ST_HAVE_A);
        end
    end

    // Operand registers for the mean stage; frozen from ISSUE through HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_a_r <= 32'h0000_0000;
            pair_b_r <= 32'h0000_0000;
        end else begin
            if (load_a_s) begin
                pair_a_r <= in_data;
            end
            if (load_b_s) begin
                pair_b_r <= in_data;
            end else if (copy_b_s) begin
                pair_b_r <= pair_a_r;
            end
        end
    end

    // Wait counter and the previous-sample register used for rising-edge detection on mean_rdy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= 8'd0;
            rdy_prev_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    cnt_r      <= 8'd0;
                    rdy_prev_r <= mean_rdy;
                end
                ST_WAIT: begin
                    cnt_r      <= cnt_r + 8'd1;
                    rdy_prev_r <= mean_rdy;
                end
                default: begin
                    cnt_r      <= cnt_r;
                    rdy_prev_r <= rdy_prev_r;
                end
            endcase
        end
    end

    // Result capture on HOLD entry, valid handshake and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r    <= 32'h0000_0000;
            out_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (cap_mean_s) begin
                out_data_r  <= mean_in;
                out_valid_r <= 1'b1;
            end else if (cap_nan_s) begin
                out_data_r    <= QNAN_F32;
                out_valid_r   <= 1'b1;
                timeout_err_r <= 1'b1;
            end else if (out_xfer_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign pair_a      = pair_a_r;
    assign pair_b      = pair_b_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign timeout_err = timeout_err_r;

endmodule
